// File: rtl/board_pkg.sv
// board_pkg: board types, win-line table and scanner states shared by the board scanner
package board_pkg;
  localparam int N_CELLS = 9;
  localparam int N_LINES = 8;
  typedef logic [17:0] board_t;
  typedef enum logic [1:0] {P_NONE, P_ONE, P_TWO} player_e;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  localparam logic [3:0] LINE_CELLS [N_LINES][3] = '{
    '{4'd8, 4'd7, 4'd6}, '{4'd5, 4'd4, 4'd3}, '{4'd2, 4'd1, 4'd0},
    '{4'd8, 4'd5, 4'd2}, '{4'd7, 4'd4, 4'd1}, '{4'd6, 4'd3, 4'd0},
    '{4'd8, 4'd4, 4'd0}, '{4'd6, 4'd4, 4'd2}};
endpackage

// File: rtl/board_scanner_if.sv
// board_scanner_if: board bus from the move writer plus scan results towards the game FSM
interface board_scanner_if;
  import board_pkg::*;
  logic start;
  board_t matrix_in;
  logic busy;
  logic done;
  logic [1:0] winner;
  logic [2:0] win_line;
  logic draw;
  logic illegal;
  logic [8:0] free_mask;
  logic [3:0] first_free;
  modport master (output start, matrix_in,
                  input busy, done, winner, win_line, draw, illegal, free_mask, first_free);
  modport slave (input start, matrix_in,
                 output busy, done, winner, win_line, draw, illegal, free_mask, first_free);
endinterface

// File: rtl/board_scanner_line_eval.sv
// line_eval: reports which player, if any, owns all three cells of one line
module line_eval
  import board_pkg::*;
#(
  parameter bit P1_ON_ODD = 1'b1
) (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic [1:0] c_i,
  output player_e    owner_o
);
  localparam logic [1:0] P1 = P1_ON_ODD ? 2'b10 : 2'b01;
  localparam logic [1:0] P2 = ~P1;
  assign owner_o = (a_i != b_i || b_i != c_i) ? P_NONE :
                   a_i == P1 ? P_ONE : a_i == P2 ? P_TWO : P_NONE;
endmodule

// File: rtl/board_scanner.sv
// board_scanner: snapshots the board, scans 8 win lines one per clock, reports winner/draw/illegal; BOARD_SCANNER_FREE_CELL_EN adds free-cell outputs
module board_scanner
  import board_pkg::*;
#(
  parameter bit P1_ON_ODD = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  board_scanner_if.slave bus
);
  state_e state_q, state_d;
  board_t snap_q, snap_d;
  player_e hit_q, hit_d, owner;
  logic [2:0] line_q, line_d, hit_line_q, hit_line_d, win_line_q;
  logic [1:0] winner_q;
  logic done_q, draw_q, illegal_q, first_hit;
  logic [N_CELLS-1:0] occ, bad;
  for (genvar k = 0; k < N_CELLS; k++) begin : g_cell
    assign occ[k] = |snap_q[2*k +: 2];
    assign bad[k] = &snap_q[2*k +: 2];
  end
  line_eval #(.P1_ON_ODD(P1_ON_ODD)) u_eval (
    .a_i     (snap_q[{LINE_CELLS[line_q][0], 1'b0} +: 2]),
    .b_i     (snap_q[{LINE_CELLS[line_q][1], 1'b0} +: 2]),
    .c_i     (snap_q[{LINE_CELLS[line_q][2], 1'b0} +: 2]),
    .owner_o (owner)
  );
  always_comb begin
    first_hit  = state_q == SCAN && hit_q == P_NONE && owner != P_NONE;
    snap_d     = bus.start ? bus.matrix_in : snap_q;
    line_d     = bus.start ? 3'd0 : state_q == SCAN ? line_q + 3'd1 : line_q;
    hit_d      = bus.start ? P_NONE : first_hit ? owner : hit_q;
    hit_line_d = bus.start ? 3'd0 : first_hit ? line_q : hit_line_q;
    state_d    = bus.start ? SCAN : state_q == SCAN ? (line_q == 3'd7 ? DONE : SCAN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      line_q     <= '0;
      hit_q      <= P_NONE;
      hit_line_q <= '0;
      done_q     <= 1'b0;
      winner_q   <= '0;
      win_line_q <= '0;
      draw_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      line_q     <= line_d;
      hit_q      <= hit_d;
      hit_line_q <= hit_line_d;
      done_q     <= state_q == DONE;
      if (state_q == DONE) begin
        winner_q   <= hit_q;
        win_line_q <= hit_line_q;
        draw_q     <= &occ && hit_q == P_NONE;
        illegal_q  <= |bad;
      end
    end
  end
  assign bus.busy     = state_q == SCAN;
  assign bus.done     = done_q;
  assign bus.winner   = winner_q;
  assign bus.win_line = win_line_q;
  assign bus.draw     = draw_q;
  assign bus.illegal  = illegal_q;
`ifdef BOARD_SCANNER_FREE_CELL_EN
  logic [8:0] free_q;
  logic [3:0] ff_q, ff;
  always_comb begin
    ff = 4'hF;
    for (int k = 0; k < N_CELLS; k++) if (!occ[k]) ff = 4'(k);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      free_q <= '0;
      ff_q   <= 4'hF;
    end else if (state_q == DONE) begin
      free_q <= ~occ;
      ff_q   <= ff;
    end
  end
  assign bus.free_mask  = free_q;
  assign bus.first_free = ff_q;
`else
  assign bus.free_mask  = 9'd0;
  assign bus.first_free = 4'hF;
`endif
endmodule

// File: tb/tb_board_scanner.sv
// tb_board_scanner: directed checks of latency, results, restart and reset behaviour
module tb_board_scanner;
  import board_pkg::*;
`ifdef BOARD_SCANNER_FREE_CELL_EN
  localparam bit FREE_EN = 1'b1;
`else
  localparam bit FREE_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int lat, dones;
  board_scanner_if bus();
  board_scanner dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string t, input string n, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", t, n, o, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic kick(input board_t m);
    bus.matrix_in = m;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int l);
    l = 0;
    do begin
      step();
      l++;
    end while (!bus.done && l < 20);
    n_chk++;
    if (!bus.done) begin
      n_fail++;
      $error("FAIL wait_done expired after %0d cycles without done", l);
    end
  endtask
  task automatic chk_res(input string t, input logic [1:0] w, input logic [2:0] wl, input logic d,
                         input logic il, input logic [8:0] fm, input logic [3:0] ff);
    chk(t, "done", bus.done, 1'b1);
    chk(t, "winner", bus.winner, w);
    if (w != 2'd0) chk(t, "win_line", bus.win_line, wl);
    chk(t, "draw", bus.draw, d);
    chk(t, "illegal", bus.illegal, il);
    chk(t, "free_mask", bus.free_mask, FREE_EN ? fm : 9'd0);
    chk(t, "first_free", bus.first_free, FREE_EN ? ff : 4'hF);
  endtask
  task automatic run(input string t, input board_t m, input logic [1:0] w, input logic [2:0] wl,
                     input logic d, input logic il, input logic [8:0] fm, input logic [3:0] ff);
    kick(m);
    chk(t, "busy_on", bus.busy, 1'b1);
    wait_done(lat);
    chk(t, "latency", lat, 9);
    chk_res(t, w, wl, d, il, fm, ff);
    step();
    chk(t, "done_pulse", bus.done, 1'b0);
    chk(t, "busy_off", bus.busy, 1'b0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.matrix_in = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset", "busy", bus.busy, 1'b0);
    chk("reset", "done", bus.done, 1'b0);
    chk("reset", "winner", bus.winner, 2'd0);
    chk("reset", "draw", bus.draw, 1'b0);
    chk("reset", "illegal", bus.illegal, 1'b0);
    chk("reset", "free_mask", bus.free_mask, 9'd0);
    chk("reset", "first_free", bus.first_free, 4'hF);
    run("p1_row0", 18'h2A000, 2'd1, 3'd0, 1'b0, 1'b0, 9'h03F, 4'd5);
    kick(18'h10101);
    chk("hold", "winner", bus.winner, 2'd1);
    wait_done(lat);
    chk("p2_diag", "latency", lat, 9);
    chk_res("p2_diag", 2'd2, 3'd6, 1'b0, 1'b0, 9'h0EE, 4'd7);
    run("draw", 18'h2695A, 2'd0, 3'd0, 1'b1, 1'b0, 9'h000, 4'hF);
    run("both", 18'h1502A, 2'd2, 3'd0, 1'b0, 1'b0, 9'h038, 4'd5);
    kick(18'h00000);
    repeat (3) begin
      step();
      chk("restart", "early_done", bus.done, 1'b0);
    end
    kick(18'h2A000);
    wait_done(lat);
    chk("restart", "latency", lat, 9);
    chk_res("restart", 2'd1, 3'd0, 1'b0, 1'b0, 9'h03F, 4'd5);
    dones = 0;
    repeat (12) begin
      step();
      if (bus.done) dones++;
    end
    chk("restart", "extra_done", dones, 0);
    run("illegal", 18'h00003, 2'd0, 3'd0, 1'b0, 1'b1, 9'h1FE, 4'd8);
    kick(18'h10101);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst", "busy", bus.busy, 1'b0);
    chk("mid_rst", "done", bus.done, 1'b0);
    chk("mid_rst", "illegal", bus.illegal, 1'b0);
    chk("mid_rst", "first_free", bus.first_free, 4'hF);
    dones = 0;
    repeat (12) begin
      step();
      if (bus.done) dones++;
    end
    chk("mid_rst", "no_done", dones, 0);
    chk("mid_rst", "winner", bus.winner, 2'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
